// File: rtl/f2s_pulse_sched.sv
// Source-domain scheduler sharing one feedback-handshake pulse synchronizer
// channel among N_REQ requesters, with round-robin grant and HOLD timeout.

module f2s_pulse_lane (
  input  logic aclk,
  input  logic rst,
  input  logic evt,
  input  logic clr,
  input  logic fin,
  output logic pend,
  output logic overrun,
  output logic done
);
  // A new event wins over a same-cycle grant clear; it only coalesces if it
  // lands on a still-pending (not just granted) event.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      pend    <= 1'b0;
      overrun <= 1'b0;
      done    <= 1'b0;
    end else begin
      pend    <= evt | (pend & ~clr);
      overrun <= evt & pend & ~clr;
      done    <= fin;
    end
  end
endmodule

module f2s_pulse_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_pulse,
  input  logic             sync_ack,
  output logic             sync_req,
  output logic [ID_W-1:0]  sync_id,
  output logic [N_REQ-1:0] pend,
  output logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] overrun,
  output logic             err_timeout,
  output logic             busy
);
  localparam logic [1:0]      IDLE    = 2'd0;
  localparam logic [1:0]      HOLD    = 2'd1;
  localparam logic [1:0]      RELEASE = 2'd2;
  localparam logic [ID_W-1:0] LAST    = ID_W'(N_REQ - 1);
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT);

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [TO_W-1:0]  cnt;
  logic             acked;
  logic             grant_go;
  logic             grant_hit;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  idx;
  logic             rel_done;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] fin;

  // First pending bit strictly after ptr, wrapping at N_REQ-1.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    idx       = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (idx == LAST) ? '0 : idx + 1'b1;
      if (!grant_hit && pend[idx]) begin
        grant_hit = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // A still-high ack in IDLE is stale from the last transaction; never grant on it.
  assign grant_go = (state == IDLE) && grant_hit && !sync_ack;
  assign rel_done = (state == RELEASE) && !sync_ack;
  assign busy     = (state != IDLE);

  always_comb begin
    clr = '0;
    fin = '0;
    for (int i = 0; i < N_REQ; i++) begin
      clr[i] = grant_go && (grant_idx == ID_W'(i));
      fin[i] = rel_done && acked && (sync_id == ID_W'(i));
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    f2s_pulse_lane u_lane (
      .aclk    (aclk),
      .rst     (rst),
      .evt     (req_pulse[i]),
      .clr     (clr[i]),
      .fin     (fin[i]),
      .pend    (pend[i]),
      .overrun (overrun[i]),
      .done    (done[i])
    );
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= LAST;
      sync_id     <= '0;
      sync_req    <= 1'b0;
      cnt         <= '0;
      acked       <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_go) begin
            sync_id  <= grant_idx;
            ptr      <= grant_idx;
            sync_req <= 1'b1;
            cnt      <= '0;
            acked    <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (sync_ack) begin
            sync_req <= 1'b0;
            acked    <= 1'b1;
            state    <= RELEASE;
          end else if (cnt == TO_LIM) begin
            sync_req    <= 1'b0;
            err_timeout <= 1'b1;
            state       <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!sync_ack) state <= IDLE;
        end
        default: begin
          sync_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_f2s_pulse_sched.sv
// Directed bench for f2s_pulse_sched: ack responder, grant/done logger and
// hand-computed expectations per scenario.

module tb_f2s_pulse_sched;
  logic       aclk = 1'b0;
  logic       rst  = 1'b1;
  logic [3:0] req_pulse = '0;
  logic       sync_ack;
  logic       sync_req;
  logic [1:0] sync_id;
  logic [3:0] pend, done, overrun;
  logic       err_timeout, busy;

  int n_chk = 0;
  int n_bad = 0;
  bit ack_en = 1'b1;

  int grants[$];
  int dones[$];
  int gaps[$];
  int hi_lens[$];
  int ovr_cnt[4];
  int to_cnt;
  int idle_run, hi_run;
  logic prev_req;

  f2s_pulse_sched #(.N_REQ(4), .ID_W(2), .TIMEOUT(255), .TO_W(8)) dut (
    .aclk        (aclk),
    .rst         (rst),
    .req_pulse   (req_pulse),
    .sync_ack    (sync_ack),
    .sync_req    (sync_req),
    .sync_id     (sync_id),
    .pend        (pend),
    .done        (done),
    .overrun     (overrun),
    .err_timeout (err_timeout),
    .busy        (busy)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Responder: ack rises 3 cycles after req is seen, falls 3 cycles later.
  initial begin
    sync_ack = 1'b0;
    forever begin
      @(negedge aclk);
      if (ack_en && sync_req && !sync_ack) begin
        repeat (3) @(negedge aclk);
        sync_ack = 1'b1;
        repeat (3) @(negedge aclk);
        sync_ack = 1'b0;
      end
    end
  end

  initial begin
    prev_req = 1'b0;
    idle_run = 0;
    hi_run   = 0;
    forever begin
      @(negedge aclk);
      if (sync_req && !prev_req) begin
        grants.push_back(int'(sync_id));
        gaps.push_back(idle_run);
        idle_run = 0;
      end
      if (!sync_req && prev_req) begin
        hi_lens.push_back(hi_run);
        hi_run = 0;
      end
      if (sync_req) hi_run++;
      if (!busy) idle_run++;
      for (int i = 0; i < 4; i++) begin
        if (done[i]) dones.push_back(i);
        if (overrun[i]) ovr_cnt[i]++;
      end
      if (err_timeout) to_cnt++;
      prev_req = sync_req;
    end
  end

  task automatic clear_log();
    grants.delete();
    dones.delete();
    gaps.delete();
    hi_lens.delete();
    for (int i = 0; i < 4; i++) ovr_cnt[i] = 0;
    to_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge aclk);
    rst = 1'b0;
    clear_log();
    @(negedge aclk);
  endtask

  task automatic pulse(input logic [3:0] v);
    req_pulse = v;
    @(negedge aclk);
    req_pulse = '0;
  endtask

  task automatic wait_quiet(input string tag, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge aclk);
      if (!busy && pend == '0 && !sync_req) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
    repeat (2) @(negedge aclk);
  endtask

  task automatic wait_req(input string tag, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (sync_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    bit hit;
    // single event, full handshake
    @(negedge aclk);
    do_reset();
    chk("rst_req", 32'(sync_req), 0);
    chk("rst_id", 32'(sync_id), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_timeout), 0);
    pulse(4'b0001);
    chk("t1_pend", 32'(pend), 32'h1);
    chk("t1_req_lo", 32'(sync_req), 0);
    @(negedge aclk);
    chk("t1_req_hi", 32'(sync_req), 1);
    chk("t1_id", 32'(sync_id), 0);
    chk("t1_pend_clr", 32'(pend), 0);
    repeat (3) @(negedge aclk);
    chk("t1_req_hold", 32'(sync_req), 1);
    @(negedge aclk);
    chk("t1_req_fall", 32'(sync_req), 0);
    chk("t1_busy_rel", 32'(busy), 1);
    repeat (3) @(negedge aclk);
    chk("t1_done", 32'(done), 32'h1);
    @(negedge aclk);
    chk("t1_done_once", 32'(done), 0);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_ndone", 32'(dones.size()), 1);

    // all four at once: rotation and one idle cycle between grants
    do_reset();
    pulse(4'b1111);
    wait_quiet("t2_quiet", 200);
    chk("t2_ngrant", 32'(grants.size()), 4);
    chk("t2_ndone", 32'(dones.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_grant%0d", i), 32'(grants[i]), 32'(i));
      chk($sformatf("t2_done%0d", i), 32'(dones[i]), 32'(i));
      if (i > 0) chk($sformatf("t2_gap%0d", i), 32'(gaps[i]), 1);
    end

    // coalescing while blocked by a stale ack, then re-pulse during HOLD
    do_reset();
    ack_en   = 1'b0;
    sync_ack = 1'b1;
    pulse(4'b0100);
    pulse(4'b0100);
    pulse(4'b0100);
    @(negedge aclk);
    chk("t3_pend", 32'(pend), 32'h4);
    chk("t3_ovr", 32'(ovr_cnt[2]), 2);
    chk("t3_stale_req", 32'(sync_req), 0);
    chk("t3_stale_busy", 32'(busy), 0);
    sync_ack = 1'b0;
    ack_en   = 1'b1;
    wait_req("t3_wait_req", 10);
    pulse(4'b0100);
    wait_quiet("t3_quiet", 200);
    chk("t3_ngrant", 32'(grants.size()), 2);
    chk("t3_g0", 32'(grants[0]), 2);
    chk("t3_g1", 32'(grants[1]), 2);
    chk("t3_ndone", 32'(dones.size()), 2);
    chk("t3_ovr_final", 32'(ovr_cnt[2]), 2);

    // silent channel: timeout on 0, then requester 1 is served
    do_reset();
    ack_en   = 1'b0;
    sync_ack = 1'b0;
    pulse(4'b0011);
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (err_timeout) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t4_err_seen", 32'(hit), 1);
    chk("t4_req_drop", 32'(sync_req), 0);
    chk("t4_hi_len", (hi_lens.size() > 0) ? 32'(hi_lens[0]) : 32'd0, 256);
    ack_en = 1'b1;
    wait_quiet("t4_quiet", 100);
    chk("t4_nto", 32'(to_cnt), 1);
    chk("t4_ngrant", 32'(grants.size()), 2);
    chk("t4_g1", 32'(grants[1]), 1);
    chk("t4_ndone", 32'(dones.size()), 1);
    chk("t4_done_id", 32'(dones[0]), 1);

    // ack stuck high blocks grants until released
    do_reset();
    ack_en   = 1'b0;
    sync_ack = 1'b1;
    pulse(4'b0010);
    repeat (5) @(negedge aclk);
    chk("t5_req", 32'(sync_req), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_pend", 32'(pend), 32'h2);
    sync_ack = 1'b0;
    ack_en   = 1'b1;
    @(negedge aclk);
    chk("t5_grant_req", 32'(sync_req), 1);
    chk("t5_grant_id", 32'(sync_id), 1);
    wait_quiet("t5_quiet", 100);

    // asynchronous reset during HOLD
    do_reset();
    ack_en   = 1'b0;
    sync_ack = 1'b0;
    pulse(4'b0001);
    wait_req("t6_wait_req", 10);
    pulse(4'b1100);
    chk("t6_pend_pre", 32'(pend), 32'hC);
    chk("t6_busy_pre", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_req", 32'(sync_req), 0);
    chk("t6_async_pend", 32'(pend), 0);
    chk("t6_async_busy", 32'(busy), 0);
    @(negedge aclk);
    rst = 1'b0;
    repeat (10) @(negedge aclk);
    chk("t6_no_start", 32'(busy), 0);
    chk("t6_ngrant", 32'(grants.size()), 1);
    ack_en = 1'b1;
    pulse(4'b0010);
    wait_quiet("t6_quiet", 100);
    chk("t6_ngrant2", 32'(grants.size()), 2);
    chk("t6_g_new", 32'(grants[1]), 1);
    chk("t6_ndone", 32'(dones.size()), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, want completion");
    $fatal(1, "watchdog");
  end
endmodule
